instr_field_decoder: RTL
========================

// Module: instr_field_decoder
// PURPOSE
//   Registered instruction-field extractor with valid/ready flow control.
//   Takes an INSTR_W-bit instruction word; delivers its flag bit, register
//   index and opcode fields one cycle later through a 2-entry elastic (skid)
//   buffer. Counts delivered instructions.
//   Sits between instruction fetch and the decode/register-file stage.
// PARAMETERS
//   INSTR_W   16  instruction word width
//   FLAG_BIT  2   bit position of the flag field
//   REG_LSB   0   LSB of the register-index field
//   REG_W     4   register-index field width
//   OPC_LSB   12  LSB of the opcode field
//   OPC_W     4   opcode field width
//   CNT_W     8   delivered-instruction counter width
//   Elaboration error if FLAG_BIT>=INSTR_W, REG_LSB+REG_W>INSTR_W or OPC_LSB+OPC_W>INSTR_W.
// PORTS
//   clk         in   1        clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   in_valid    in   1        in_instr is valid
//   in_ready    out  1        block accepts in_instr this cycle
//   in_instr    in   INSTR_W  instruction word
//   out_valid   out  1        output fields are valid
//   out_ready   in   1        consumer accepts outputs this cycle
//   out_flag    out  1        in_instr[FLAG_BIT]
//   out_reg     out  REG_W    in_instr[REG_LSB +: REG_W]
//   out_opcode  out  OPC_W    in_instr[OPC_LSB +: OPC_W]
//   out_reg_z   out  1        1 when out_reg == 0
//   out_count   out  CNT_W    number of completed output handshakes, mod 2^CNT_W
// BEHAVIOUR
//   Reset (rst_n=0, async): out_valid=0, in_ready=0, all data outputs=0,
//     out_count=0, skid entry empty. in_ready goes 1 at first clk edge after release.
//   Accept: in_valid & in_ready at edge. Deliver: out_valid & out_ready at edge.
//   States (main=output reg, skid=spare): EMPTY, ONE (main full), TWO (both full).
//   EMPTY: accept -> ONE; fields registered, out_valid=1 next cycle (latency 1).
//   ONE: accept & deliver -> ONE (main reloaded from in_instr);
//        accept only -> TWO (word stored in skid); deliver only -> EMPTY.
//   TWO: in_ready=0; deliver -> ONE (skid moves to main, order preserved).
//   in_ready = registered, = 0 in TWO, 1 otherwise (after reset release); no
//     combinational path from out_ready to in_ready.
//   in_valid while in_ready=0 is ignored; producer holds word (no drop, no dup).
//   out_* fields stable while out_valid & ~out_ready.
//   out_reg_z registered with out_reg, never combinational from in_instr.
//   out_count increments by 1 per deliver, wraps 2^CNT_W-1 -> 0, no saturation.
//   Reset mid-operation: any buffered words discarded, counter cleared.
//   Data outputs when out_valid=0: hold last delivered value (don't-care to consumer).
// TESTING
//   Reset then in_instr=16'h3333 1 cycle, out_ready=1 -> next cycle out_valid=1,
//     flag=0, reg=3, opcode=3, reg_z=0, count=1 after the handshake.
//   Stream 16'h0004,16'hA000,16'h0010 back-to-back, out_ready=1 -> outputs
//     (1,4,0,0),(0,0,A,1),(0,0,0,1) on consecutive cycles, in_ready stays 1.
//   out_ready=0, send 16'h1111 then 16'h2222 -> in_ready=0 after 2nd accept;
//     raise out_ready -> 1111 then 2222 delivered in order, in_ready returns 1.
//   Random in_valid/out_ready (50%) for 10k words -> scoreboard: no loss,
//     duplication or reorder; out_count == delivered mod 256.
//   Deliver 256 words (CNT_W=8) -> out_count wraps 255 -> 0.
//   Assert rst_n=0 with TWO full -> outputs/counter 0 immediately, skid empty.

Source files
------------

// File: rtl/instr_field_decoder.sv
// Registered flag/register/opcode field extractor behind a 2-entry skid buffer.
// The main register drives the outputs; the skid register absorbs one word when the consumer stalls.
module instr_field_decoder #(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned FLAG_BIT = 2,
    parameter int unsigned REG_LSB  = 0,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned OPC_LSB  = 12,
    parameter int unsigned OPC_W    = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_flag,
    output logic [REG_W-1:0]   out_reg,
    output logic [OPC_W-1:0]   out_opcode,
    output logic               out_reg_z,
    output logic [CNT_W-1:0]   out_count
);

    if (FLAG_BIT >= INSTR_W) begin : gen_bad_flag
        $error("FLAG_BIT must lie inside the instruction word");
    end
    if (REG_LSB + REG_W > INSTR_W) begin : gen_bad_reg
        $error("register-index field exceeds the instruction word");
    end
    if (OPC_LSB + OPC_W > INSTR_W) begin : gen_bad_opc
        $error("opcode field exceeds the instruction word");
    end

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    // Packed field layout: {opcode, reg, reg_z, flag}
    localparam int unsigned FieldW = OPC_W + REG_W + 2;

    state_e              state_q, state_d;
    logic [FieldW-1:0]   main_q, main_d;
    logic [FieldW-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic [FieldW-1:0]   in_fields;
    logic                accept, deliver;

    assign in_fields = {in_instr[OPC_LSB +: OPC_W],
                        in_instr[REG_LSB +: REG_W],
                        (in_instr[REG_LSB +: REG_W] == '0),
                        in_instr[FLAG_BIT]};

    assign accept  = in_valid & in_ready_q;
    assign deliver = (state_q != StEmpty) & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;
        if (deliver) begin
            count_d = count_q + CNT_W'(1);
        end
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = in_fields;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && deliver) begin
                    main_d = in_fields;
                end else if (accept) begin
                    skid_d  = in_fields;
                    state_d = StTwo;
                end else if (deliver) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Registered from the next state so out_ready never reaches in_ready combinationally
        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != StEmpty);
    assign out_flag   = main_q[0];
    assign out_reg_z  = main_q[1];
    assign out_reg    = main_q[2 +: REG_W];
    assign out_opcode = main_q[2 + REG_W +: OPC_W];
    assign out_count  = count_q;

endmodule
